// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the receive path now and by a future transmit path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int MID_SAMPLE     = OVERSAMPLE_DEF / 2 - 1;

   // Tick count at which the start bit is re-checked (mid bit).
   function automatic int mid_sample(input int os);
      return os / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high lines reset to 1.
module uart_sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; only q is used downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receive engine with 16x oversampling and per-frame error flags.
// Delivers bytes on a valid/ready handshake; overrun drops the new frame.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_tick,
   input  logic                  rx_i,
   input  logic                  cfg_parity_en,
   input  logic                  cfg_parity_odd,
   input  logic                  cfg_stop2,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  overrun_err,
   output logic                  rx_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH + 1);

   localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] MID_CNT  = CW'(mid_sample(OVERSAMPLE));
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   logic                  rx_s;
   rx_state_e             state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  armed_q, armed_d;
   logic                  stop_q, stop_d;
   logic                  perr_q, perr_d;
   logic                  ferr_q, ferr_d;
   logic                  done;

   uart_sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (rx_i),
      .q    (rx_s)
   );

   assign rx_busy = (state_q != IDLE);

   // Frame FSM state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         armed_q <= 1'b0;
         stop_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         armed_q <= armed_d;
         stop_q  <= stop_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state logic; everything advances only on rx_tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      armed_d = armed_q;
      stop_d  = stop_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      done    = 1'b0;
      if (rx_tick) begin
         unique case (state_q)
            IDLE: begin
               if (!armed_q) begin
                  armed_d = rx_s;
               end else if (!rx_s) begin
                  state_d = START;
                  cnt_d   = '0;
                  armed_d = 1'b0;
               end
            end
            START: begin
               if (cnt_q == MID_CNT) begin
                  if (!rx_s) begin
                     state_d = DATA;
                     cnt_d   = '0;
                     bit_d   = '0;
                     perr_d  = 1'b0;
                     ferr_d  = 1'b0;
                     stop_d  = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                  if (bit_q == LAST_BIT) begin
                     state_d = cfg_parity_en ? PARITY : STOP;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PARITY: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  perr_d  = ((^shift_q) ^ rx_s) != cfg_parity_odd;
                  state_d = STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d  = '0;
                  ferr_d = ferr_q | ~rx_s;
                  if (cfg_stop2 && !stop_q) begin
                     stop_d = 1'b1;
                  end else begin
                     state_d = IDLE;
                     done    = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output holding register: a same-cycle accept frees the slot first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (done) begin
            if (rx_valid && !rx_ready) begin
               overrun_err <= 1'b1;
            end else begin
               rx_data    <= shift_q;
               parity_err <= perr_q;
               frame_err  <= ferr_d;
               rx_valid   <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
